// File: rtl/sn2bn_counter.sv
// sn2bn_counter: stochastic-to-binary decoder counting ones per lane over a 2**NUM_BIT valid-bit window
// Ports:
//   i_clk_sn2bn   clock, rising edge
//   i_rst_sn2bn   asynchronous active-low reset
//   i_start_sn2bn pulse: clear counters and open a window
//   i_stop_sn2bn  abort the open window (wins over start)
//   i_valid_sn2bn qualifies i_sn_bit
//   i_sn_bit      one stream bit per lane
//   o_x_bn        decoded value per lane, held until next window completes
//   o_sat         lane saw all ones and was clipped to 2**NUM_BIT-1
//   o_busy        window open
//   o_done        one-cycle pulse when o_x_bn/o_sat update
module sn2bn_counter #(
  parameter int NUM_BIT = 8,
  parameter int DIM = 4
) (
  input  logic                           i_clk_sn2bn,
  input  logic                           i_rst_sn2bn,
  input  logic                           i_start_sn2bn,
  input  logic                           i_stop_sn2bn,
  input  logic                           i_valid_sn2bn,
  input  logic [DIM-1:0]                 i_sn_bit,
  output logic [DIM-1:0][NUM_BIT-1:0]    o_x_bn,
  output logic [DIM-1:0]                 o_sat,
  output logic                           o_busy,
  output logic                           o_done
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [NUM_BIT:0] LAST = {1'b0, {NUM_BIT{1'b1}}};
  state_t state;
  logic [DIM-1:0][NUM_BIT:0] lane_cnt, nxt;
  logic [NUM_BIT:0] bit_cnt;
  logic go;
  assign go = i_start_sn2bn && !i_stop_sn2bn;
  assign o_busy = state == ACC;
  always_comb
    for (int k = 0; k < DIM; k++) nxt[k] = lane_cnt[k] + {{NUM_BIT{1'b0}}, i_sn_bit[k]};
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_sn2bn)
    if (!i_rst_sn2bn) begin
      state <= IDLE;
      lane_cnt <= '0;
      bit_cnt <= '0;
      o_x_bn <= '0;
      o_sat <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (go) begin
        lane_cnt <= '0;
        bit_cnt <= '0;
      end
      case (state)
        IDLE: if (go) state <= ACC;
        ACC:
          if (i_stop_sn2bn) state <= IDLE;
          else if (!i_start_sn2bn && i_valid_sn2bn) begin
            lane_cnt <= nxt;
            bit_cnt <= bit_cnt + (NUM_BIT+1)'(1);
            // outputs are registered from the final bit directly so they appear in the DONE cycle
            if (bit_cnt == LAST) begin
              state <= DONE;
              o_done <= 1'b1;
              for (int k = 0; k < DIM; k++) begin
                o_x_bn[k] <= nxt[k][NUM_BIT] ? '1 : nxt[k][NUM_BIT-1:0];
                o_sat[k] <= nxt[k][NUM_BIT];
              end
            end
          end
        default: state <= go ? ACC : IDLE;
      endcase
    end
endmodule
